// File: rtl/uart_rom_loader_pkg.sv
//------------------------------------------------------------------------------
// Module : uart_rom_loader_pkg
// Brief  : Shared widths, sync byte and loader state encodings.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_rom_loader_pkg;

    localparam int         c_MEM_ADDR_W = 32;
    localparam int         c_INST_W     = 32;
    localparam logic [7:0] c_SYNC_BYTE  = 8'hA5;

    localparam logic [2:0] c_L_IDLE = 3'd0;
    localparam logic [2:0] c_L_LEN0 = 3'd1;
    localparam logic [2:0] c_L_LEN1 = 3'd2;
    localparam logic [2:0] c_L_DATA = 3'd3;
    localparam logic [2:0] c_L_CSUM = 3'd4;
    localparam logic [2:0] c_L_DONE = 3'd5;

endpackage

`default_nettype wire

// File: rtl/uart_rom_loader_rx.sv
//------------------------------------------------------------------------------
// Module : uart_rx
// Brief  : 8N1 UART receiver with 2-FF synchroniser and stop-bit check.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_RX_IDLE  = 2'd0;
    localparam logic [1:0] c_RX_START = 2'd1;
    localparam logic [1:0] c_RX_DATA  = 2'd2;
    localparam logic [1:0] c_RX_STOP  = 2'd3;

    logic [1:0]         r_sync;
    logic               r_rx_prev;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               w_rx;
    logic               w_fall;
    logic               w_half_tick;
    logic               w_bit_tick;

    assign w_rx        = r_sync[1];
    assign w_fall      = r_rx_prev & ~w_rx;
    assign w_half_tick = (r_cnt == c_HALF_LAST);
    assign w_bit_tick  = (r_cnt == c_BIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_RX_IDLE:  if (w_fall) w_state_nxt = c_RX_START;
            // Start bit re-checked at mid-bit; a high level means a glitch
            c_RX_START: if (w_half_tick) w_state_nxt = w_rx ? c_RX_IDLE : c_RX_DATA;
            c_RX_DATA:  if (w_bit_tick && (r_bit == 3'd7)) w_state_nxt = c_RX_STOP;
            c_RX_STOP:  if (w_bit_tick) w_state_nxt = c_RX_IDLE;
            default:    w_state_nxt = c_RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_rx_prev    <= 1'b1;
            r_state      <= c_RX_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], rx_i};
            r_rx_prev    <= w_rx;
            r_state      <= w_state_nxt;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            if ((r_state == c_RX_IDLE) || w_bit_tick || ((r_state == c_RX_START) && w_half_tick))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state == c_RX_IDLE)
                r_bit <= '0;
            if ((r_state == c_RX_DATA) && w_bit_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if ((r_state == c_RX_STOP) && w_bit_tick) begin
                if (w_rx) begin
                    byte_o       <= r_shift;
                    byte_valid_o <= 1'b1;
                end else begin
                    frame_err_o  <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rom_loader.sv
//------------------------------------------------------------------------------
// Module : uart_rom_loader
// Brief  : Loads a framed program image from UART into the instruction ROM
//          and holds the core in reset while loading. Optional trailing XOR
//          checksum byte enabled by LOADER_CHECKSUM_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int          CLK_FREQ       = 50000000,
    parameter int          BAUD           = 115200,
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter int          MAX_WORDS      = 4096,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_i,
    output logic                    rom_we_o,
    output logic [c_MEM_ADDR_W-1:0] rom_waddr_o,
    output logic [c_INST_W-1:0]     rom_wdata_o,
    output logic                    core_rst_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int                 c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int                 c_TMO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST     = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]        c_MAX_WORDS    = 17'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0]         c_AFTER_DATA   = c_L_CSUM;
`else
    localparam logic [2:0]         c_AFTER_DATA   = c_L_DONE;
`endif

    logic [7:0]         w_rx_byte;
    logic               w_rx_valid;
    logic               w_rx_err;
    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [15:0]        r_len;
    logic [15:0]        r_idx;
    logic [23:0]        r_word;
    logic [1:0]         r_bcnt;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_hold;
    logic               r_err;
    logic               w_err;
    logic               w_busy;
    logic               w_tmo_hit;
    logic [15:0]        w_len;
    logic               w_word_done;
    logic               w_last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         r_csum;
`endif

    uart_rx #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_uart_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .byte_o       (w_rx_byte),
        .byte_valid_o (w_rx_valid),
        .frame_err_o  (w_rx_err)
    );

    assign w_busy      = (r_state != c_L_IDLE) && (r_state != c_L_DONE);
    // An arriving byte beats a simultaneous timeout expiry
    assign w_tmo_hit   = (r_tmo == c_TMO_LAST) && !w_rx_valid;
    assign w_len       = {w_rx_byte, r_len[7:0]};
    assign w_word_done = (r_state == c_L_DATA) && w_rx_valid && (r_bcnt == 2'd3);
    assign w_last_word = ((r_idx + 16'd1) == r_len);

    assign busy_o     = w_busy;
    assign done_o     = (r_state == c_L_DONE);
    assign core_rst_o = r_hold;
    assign err_o      = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            c_L_IDLE: if (w_rx_valid && (w_rx_byte == c_SYNC_BYTE)) w_state_nxt = c_L_LEN0;
            c_L_LEN0: if (w_rx_valid) w_state_nxt = c_L_LEN1;
            c_L_LEN1: begin
                if (w_rx_valid) begin
                    if ({1'b0, w_len} > c_MAX_WORDS) w_err = 1'b1;
                    else if (w_len == 16'd0)         w_state_nxt = c_AFTER_DATA;
                    else                             w_state_nxt = c_L_DATA;
                end
            end
            c_L_DATA: if (w_word_done && w_last_word) w_state_nxt = c_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            c_L_CSUM: begin
                if (w_rx_valid) begin
                    if (w_rx_byte != r_csum) w_err = 1'b1;
                    else                     w_state_nxt = c_L_DONE;
                end
            end
`endif
            c_L_DONE: w_state_nxt = c_L_IDLE;
            default:  w_state_nxt = c_L_IDLE;
        endcase
        if (w_busy && (w_rx_err || w_tmo_hit)) w_err = 1'b1;
        if (w_err) w_state_nxt = c_L_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_L_IDLE;
            r_len       <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_bcnt      <= '0;
            r_tmo       <= '0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
            rom_we_o    <= 1'b0;
            rom_waddr_o <= '0;
            rom_wdata_o <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_err    <= w_err;
            rom_we_o <= 1'b0;
            r_tmo    <= (w_busy && !w_rx_valid) ? r_tmo + 1'b1 : '0;
            if ((r_state == c_L_IDLE) && (w_state_nxt == c_L_LEN0)) begin
                r_hold <= 1'b1;
                r_idx  <= '0;
                r_bcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum <= '0;
`endif
            end
            // Hold is only released by a completed frame, never by an error
            if (w_state_nxt == c_L_DONE) r_hold <= 1'b0;
            if (w_rx_valid) begin
                case (r_state)
                    c_L_LEN0: r_len[7:0]  <= w_rx_byte;
                    c_L_LEN1: r_len[15:8] <= w_rx_byte;
                    c_L_DATA: begin
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            rom_we_o    <= 1'b1;
                            rom_waddr_o <= ROM_BASE + {14'd0, r_idx, 2'b00};
                            rom_wdata_o <= {w_rx_byte, r_word};
                            r_idx       <= r_idx + 16'd1;
                        end else begin
                            r_word <= {w_rx_byte, r_word[23:8]};
                        end
                    end
                    default: ;
                endcase
`ifdef LOADER_CHECKSUM_EN
                if ((r_state == c_L_LEN0) || (r_state == c_L_LEN1) || (r_state == c_L_DATA))
                    r_csum <= r_csum ^ w_rx_byte;
`endif
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rom_loader.sv
//------------------------------------------------------------------------------
// Module : tb_uart_rom_loader
// Brief  : Self-checking bench for uart_rom_loader (table vectors plus
//          timeout, reset and checksum sequences).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rom_loader;

    localparam int c_CPB = 16;
    localparam int c_TMO = 300;

    typedef struct {
        int           nbytes;
        logic [127:0] bytes;     // reading order, first byte most significant
        int           sync_idx;
        int           bad_idx;
        int           exp_nw;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w1;
        logic         exp_done;
        logic         exp_hold;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rx;
    logic        rom_we_o;
    logic [31:0] rom_waddr_o;
    logic [31:0] rom_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          n_done;
    int          n_err;
    int          nw;
    int          bv_stamp;
    int          err_stamp;
    logic [31:0] wa [64];
    logic [31:0] wd [64];
    vec_t        vec [6];

    uart_rom_loader #(
        .CLK_FREQ       (1600000),
        .BAUD           (100000),
        .ROM_BASE       (32'h0000_0000),
        .MAX_WORDS      (4096),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx),
        .rom_we_o    (rom_we_o),
        .rom_waddr_o (rom_waddr_o),
        .rom_wdata_o (rom_wdata_o),
        .core_rst_o  (core_rst_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0; n_done = 0; n_err = 0; nw = 0; bv_stamp = 0; err_stamp = 0;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rom_we_o) begin
            if (nw < 64) begin
                wa[nw] <= rom_waddr_o;
                wd[nw] <= rom_wdata_o;
            end
            nw <= nw + 1;
        end
        if (done_o) n_done <= n_done + 1;
        if (err_o) begin
            n_err     <= n_err + 1;
            err_stamp <= cyc + 1;
        end
        if (dut.w_rx_valid) bv_stamp <= cyc + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        rx = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (c_CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_end(input int d0, input int e0, output logic seen);
        seen = 1'b0;
        for (int c = 0; (c < 400) && !seen; c++) begin
            @(negedge clk);
            seen = (n_done != d0) || (n_err != e0);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic run_vec(input int k);
        int          d0, e0, w0;
        logic [7:0]  b;
        logic [7:0]  cs;
        logic        seen;
        d0 = n_done; e0 = n_err; w0 = nw; cs = 8'h00;
        for (int i = 0; i < vec[k].nbytes; i++) begin
            b = vec[k].bytes[(vec[k].nbytes - 1 - i) * 8 +: 8];
            if (i > vec[k].sync_idx) cs = cs ^ b;
            send_byte(b, i == vec[k].bad_idx);
            if (i == vec[k].sync_idx) begin
                chk("busy_after_sync", busy_o, 1);
                chk("hold_after_sync", core_rst_o, 1);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (vec[k].exp_done) send_byte(cs, 1'b0);
`endif
        wait_end(d0, e0, seen);
        chk("frame_end_seen", seen, 1);
        chk("done_pulses", n_done - d0, vec[k].exp_done);
        chk("err_pulses", n_err - e0, !vec[k].exp_done);
        chk("write_count", nw - w0, vec[k].exp_nw);
        if (vec[k].exp_nw > 0) begin
            chk("w0_addr", wa[w0], 32'h0);
            chk("w0_data", wd[w0], vec[k].exp_w0);
        end
        if (vec[k].exp_nw > 1) begin
            chk("w1_addr", wa[w0 + 1], 32'h4);
            chk("w1_data", wd[w0 + 1], vec[k].exp_w1);
        end
        chk("core_rst_after", core_rst_o, vec[k].exp_hold);
        chk("busy_after", busy_o, 0);
    endtask

    initial begin
        int   d0, e0, w0;
        logic seen;
        n_tests = 0;
        n_fail  = 0;
        rx  = 1'b1;
        rst = 1'b1;

        vec[0] = '{11, 128'hA5_02_00_13_00_00_00_93_00_10_00, 0, -1, 2, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0};
        vec[1] = '{4,  128'h11_A5_00_00,                      1, -1, 0, 32'h0,         32'h0,         1'b1, 1'b0};
        vec[2] = '{3,  128'hA5_01_10,                         0, -1, 0, 32'h0,         32'h0,         1'b0, 1'b1};
        vec[3] = '{5,  128'hA5_01_00_13_00,                   0,  4, 0, 32'h0,         32'h0,         1'b0, 1'b1};
        vec[4] = '{7,  128'hA5_01_00_A5_5A_3C_C3,             0, -1, 1, 32'hC33C_5AA5, 32'h0,         1'b1, 1'b0};
        vec[5] = '{3,  128'hA5_FF_FF,                         0, -1, 0, 32'h0,         32'h0,         1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {rom_we_o, rom_waddr_o, rom_wdata_o, core_rst_o, busy_o, done_o, err_o}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(k);

        // Idle bus after the length bytes: error exactly TIMEOUT cycles after the last byte
        d0 = n_done; e0 = n_err; w0 = nw;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        seen = 1'b0;
        for (int c = 0; (c < c_TMO + 100) && !seen; c++) begin
            @(negedge clk);
            seen = err_o;
        end
        chk("tmo_err_seen", seen, 1);
        chk("tmo_busy_low", busy_o, 0);
        chk("tmo_hold", core_rst_o, 1);
        repeat (2) @(negedge clk);
        chk("tmo_latency", err_stamp - bv_stamp, c_TMO + 1);
        chk("tmo_err_count", n_err - e0, 1);
        chk("tmo_no_write", nw - w0, 0);
        chk("tmo_no_done", n_done - d0, 0);

        // Reset in the middle of a word, then a clean reload
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("pre_reset_busy", busy_o, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", {rom_we_o, rom_waddr_o, rom_wdata_o, core_rst_o, busy_o, done_o, err_o}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_vec(0);

`ifdef LOADER_CHECKSUM_EN
        // Correct checksum for vec[0] is 8'h92; send a corrupted one
        d0 = n_done; e0 = n_err; w0 = nw;
        for (int i = 0; i < vec[0].nbytes; i++)
            send_byte(vec[0].bytes[(vec[0].nbytes - 1 - i) * 8 +: 8], 1'b0);
        send_byte(8'h93, 1'b0);
        wait_end(d0, e0, seen);
        chk("csum_bad_seen", seen, 1);
        chk("csum_bad_writes", nw - w0, 2);
        chk("csum_bad_err", n_err - e0, 1);
        chk("csum_bad_done", n_done - d0, 0);
        chk("csum_bad_hold", core_rst_o, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
